l2_flush_seq: RTL and testbench
===============================

Name: l2_flush_seq

Overview:
- Flush sequencer for the Spandex L2.
- On a flush request it walks every (set, way) using the flush_set/flush_way counters held in the L2 register block, and drives that block's set/clear/increment strobes.
- For each line it reads the tag/state array and issues an eviction for each valid line to the request-issue path.
- It consumes a request-table slot per eviction and signals completion once all flush evictions have drained.

Parameters:
- SET_BITS, 8, log2 of L2 set count.
- WAY_BITS, 3, log2 of L2 way count.
- N_REQS, 4, request-table entries; reqs_cnt equals N_REQS when the table is empty.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush_req  in  1  start pulse; ignored unless IDLE
- flush_busy  out  1  high in every state except IDLE
- flush_done  out  1  one-cycle pulse at completion
- flush_set  in  SET_BITS+1  current set from register block
- flush_way  in  WAY_BITS+1  current way from register block
- reqs_cnt  in  clog2(N_REQS+1)  free request slots
- set_ongoing_flush, clr_ongoing_flush  out  1  strobes to register block
- incr_flush_set, clr_flush_set, incr_flush_way, clr_flush_way  out  1  counter strobes
- fill_reqs_flush  out  1  one-cycle pulse per accepted eviction (decrements reqs_cnt)
- lookup_valid  out  1  tag/state read request
- lookup_ready  in  1  array accepts read
- lookup_set  out  SET_BITS  equals flush_set[SET_BITS-1:0]
- lookup_way  out  WAY_BITS  equals flush_way[WAY_BITS-1:0]
- lookup_rsp_valid  in  1  read data valid (any latency ≥1)
- line_valid, line_dirty  in  1  state of the looked-up line
- evict_valid  out  1  eviction request
- evict_ready  in  1  eviction accepted
- evict_set  out  SET_BITS  set of the line being evicted
- evict_way  out  WAY_BITS  way of the line being evicted

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0. Applies mid-flush: the sequence aborts with no flush_done pulse, and any in-flight lookup response is dropped.
- States and transitions:
  - IDLE: on flush_req, go to START.
  - START (1 cycle): assert set_ongoing_flush, clr_flush_set, clr_flush_way; go to LOOKUP.
  - LOOKUP: hold lookup_valid=1 until lookup_valid&&lookup_ready; then go to WAIT_RD. Counters are stable here because START/NEXT strobes land one cycle earlier.
  - WAIT_RD: wait for lookup_rsp_valid. Capture set/way into evict regs. If line_valid, go to EVICT; otherwise go to NEXT.
  - EVICT: evict_valid=1 only while reqs_cnt!=0. With reqs_cnt==0, evict_valid=0 and the block stalls. On evict_valid&&evict_ready, pulse fill_reqs_flush in the same cycle, then go to NEXT. Once asserted, evict_valid and its payload stay stable until accepted, which is guaranteed because reqs_cnt cannot drop from another source during the flush.
  - NEXT (1 cycle):
    - If flush_way==2^WAY_BITS-1 and flush_set==2^SET_BITS-1: go to DRAIN, with no strobes.
    - Else if flush_way==2^WAY_BITS-1: pulse incr_flush_set and clr_flush_way; go to LOOKUP.
    - Else: pulse incr_flush_way; go to LOOKUP.
  - DRAIN: wait until reqs_cnt==N_REQS; then pulse clr_ongoing_flush and flush_done together for one cycle and go to IDLE. flush_busy falls the following cycle.
- flush_req arriving in any non-IDLE state is dropped; it is not queued.
- Exactly one lookup is outstanding at any time; lookup_rsp_valid outside WAIT_RD is ignored.
- Walk order: way-minor, set-major; 2^(SET_BITS+WAY_BITS) lookups per flush.
- Strobes are mutually exclusive per counter, so the register block's clr-over-incr priority is never exercised.

Optional Feature:
- Macro: L2_FLUSH_SKIP_CLEAN_EN.
- Defined: WAIT_RD goes to EVICT only when line_valid&&line_dirty. Valid clean lines go straight to NEXT with no eviction and no slot consumed.
- Undefined: every valid line is evicted, and line_dirty is unused.

Test Plan:
- SET_BITS=1, WAY_BITS=1, all lines invalid, flush_req pulse -> 4 lookups at (0,0),(0,1),(1,0),(1,1); no evict_valid; flush_done one cycle after DRAIN entry, with reqs_cnt=4 held.
- Same config, all lines valid, evict_ready=1, reqs_cnt model returns slots after 3 cycles -> 4 evictions with matching set/way; 4 fill_reqs_flush pulses; flush_done only after reqs_cnt returns to 4.
- reqs_cnt forced to 0 in EVICT for 10 cycles -> evict_valid low for those cycles; asserts the cycle reqs_cnt=1; payload unchanged until handshake.
- lookup_ready low 5 cycles, response latency 3 -> lookup_set/way stable while waiting; no duplicate lookup; flush_set/flush_way unchanged until NEXT.
- rst asserted in EVICT, then flush_req the cycle after rst drops -> all outputs 0 during reset; new flush restarts at (0,0) with set_ongoing_flush and clr strobes; no flush_done from the aborted run.
- With L2_FLUSH_SKIP_CLEAN_EN, lines valid and dirty only at (1,0) -> exactly one eviction, at set 1 way 0; flush_req during busy causes no second flush.

Source files
------------

// File: rtl/l2_flush_seq_if.sv
// Tag/state lookup and eviction handshake bundle between the L2 flush sequencer
// (master) and the L2 array / request-issue path (slave).
interface l2_flush_seq_if #(
  parameter int SET_BITS = 8,
  parameter int WAY_BITS = 3
);
  logic                lookup_valid;
  logic                lookup_ready;
  logic [SET_BITS-1:0] lookup_set;
  logic [WAY_BITS-1:0] lookup_way;
  logic                lookup_rsp_valid;
  logic                line_valid;
  logic                line_dirty;
  logic                evict_valid;
  logic                evict_ready;
  logic [SET_BITS-1:0] evict_set;
  logic [WAY_BITS-1:0] evict_way;

  modport master (
    output lookup_valid, lookup_set, lookup_way, evict_valid, evict_set, evict_way,
    input  lookup_ready, lookup_rsp_valid, line_valid, line_dirty, evict_ready
  );

  modport slave (
    input  lookup_valid, lookup_set, lookup_way, evict_valid, evict_set, evict_way,
    output lookup_ready, lookup_rsp_valid, line_valid, line_dirty, evict_ready
  );
endinterface

// File: rtl/l2_flush_seq.sv
// Spandex L2 flush sequencer: walks every (set, way), evicts valid lines, drains slots.
// Optional macro L2_FLUSH_SKIP_CLEAN_EN: evict only lines that are valid and dirty.
module l2_flush_seq #(
  parameter int SET_BITS = 8,
  parameter int WAY_BITS = 3,
  parameter int N_REQS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_req,
  output logic                          flush_busy,
  output logic                          flush_done,
  input  logic [SET_BITS:0]             flush_set,
  input  logic [WAY_BITS:0]             flush_way,
  input  logic [$clog2(N_REQS+1)-1:0]   reqs_cnt,
  output logic                          set_ongoing_flush,
  output logic                          clr_ongoing_flush,
  output logic                          incr_flush_set,
  output logic                          clr_flush_set,
  output logic                          incr_flush_way,
  output logic                          clr_flush_way,
  output logic                          fill_reqs_flush,
  l2_flush_seq_if.master                bus
);
  localparam int CNT_W = $clog2(N_REQS+1);
  localparam logic [CNT_W-1:0]    FULL     = CNT_W'(N_REQS);
  localparam logic [SET_BITS:0]   LAST_SET = {1'b0, {SET_BITS{1'b1}}};
  localparam logic [WAY_BITS:0]   LAST_WAY = {1'b0, {WAY_BITS{1'b1}}};

  typedef enum logic [2:0] {IDLE, START, LOOKUP, WAIT_RD, EVICT, NEXT, DRAIN} state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                set_on_q, set_on_d, clr_on_q, clr_on_d;
  logic                incr_set_q, incr_set_d, clr_set_q, clr_set_d;
  logic                incr_way_q, incr_way_d, clr_way_q, clr_way_d;
  logic                lookup_valid_q, lookup_valid_d;
  logic [SET_BITS-1:0] evict_set_q, evict_set_d;
  logic [WAY_BITS-1:0] evict_way_q, evict_way_d;
  logic                take_line, last_way, last_set, evict_fire, to_next;

`ifdef L2_FLUSH_SKIP_CLEAN_EN
  assign take_line = bus.line_valid && bus.line_dirty;
`else
  logic unused_dirty;
  assign unused_dirty = bus.line_dirty;
  assign take_line    = bus.line_valid;
`endif

  assign last_way   = (flush_way == LAST_WAY);
  assign last_set   = (flush_set == LAST_SET);
  assign evict_fire = bus.evict_valid && bus.evict_ready;

  // Counter strobes are decided on the way into NEXT and registered, so they are
  // visible during NEXT and the register block updates before the next LOOKUP.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    set_on_d    = 1'b0;
    clr_on_d    = 1'b0;
    incr_set_d  = 1'b0;
    clr_set_d   = 1'b0;
    incr_way_d  = 1'b0;
    clr_way_d   = 1'b0;
    to_next     = 1'b0;
    evict_set_d = evict_set_q;
    evict_way_d = evict_way_q;
    unique case (state_q)
      IDLE: begin
        // busy_q still high during the done pulse; a request then is dropped
        if (flush_req && !busy_q) begin
          state_d   = START;
          set_on_d  = 1'b1;
          clr_set_d = 1'b1;
          clr_way_d = 1'b1;
        end
      end
      START:  state_d = LOOKUP;
      LOOKUP: if (lookup_valid_q && bus.lookup_ready) state_d = WAIT_RD;
      WAIT_RD: begin
        if (bus.lookup_rsp_valid) begin
          evict_set_d = flush_set[SET_BITS-1:0];
          evict_way_d = flush_way[WAY_BITS-1:0];
          if (take_line) state_d = EVICT;
          else           to_next = 1'b1;
        end
      end
      EVICT:  if (evict_fire) to_next = 1'b1;
      NEXT:   state_d = (last_way && last_set) ? DRAIN : LOOKUP;
      DRAIN: begin
        if (reqs_cnt == FULL) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          clr_on_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (to_next) begin
      state_d = NEXT;
      if (last_way && !last_set) begin
        incr_set_d = 1'b1;
        clr_way_d  = 1'b1;
      end else if (!last_way) begin
        incr_way_d = 1'b1;
      end
    end
    busy_d         = (state_d != IDLE) || done_d;
    lookup_valid_d = (state_d == LOOKUP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      set_on_q       <= 1'b0;
      clr_on_q       <= 1'b0;
      incr_set_q     <= 1'b0;
      clr_set_q      <= 1'b0;
      incr_way_q     <= 1'b0;
      clr_way_q      <= 1'b0;
      lookup_valid_q <= 1'b0;
      evict_set_q    <= '0;
      evict_way_q    <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      set_on_q       <= set_on_d;
      clr_on_q       <= clr_on_d;
      incr_set_q     <= incr_set_d;
      clr_set_q      <= clr_set_d;
      incr_way_q     <= incr_way_d;
      clr_way_q      <= clr_way_d;
      lookup_valid_q <= lookup_valid_d;
      evict_set_q    <= evict_set_d;
      evict_way_q    <= evict_way_d;
    end
  end

  assign flush_busy        = busy_q;
  assign flush_done        = done_q;
  assign set_ongoing_flush = set_on_q;
  assign clr_ongoing_flush = clr_on_q;
  assign incr_flush_set    = incr_set_q;
  assign clr_flush_set     = clr_set_q;
  assign incr_flush_way    = incr_way_q;
  assign clr_flush_way     = clr_way_q;

  assign bus.lookup_valid  = lookup_valid_q;
  assign bus.lookup_set    = lookup_valid_q ? flush_set[SET_BITS-1:0] : '0;
  assign bus.lookup_way    = lookup_valid_q ? flush_way[WAY_BITS-1:0] : '0;
  assign bus.evict_valid   = (state_q == EVICT) && (reqs_cnt != '0);
  assign bus.evict_set     = evict_set_q;
  assign bus.evict_way     = evict_way_q;
  assign fill_reqs_flush   = evict_fire;
endmodule

// File: tb/tb_l2_flush_seq.sv
// Bench for l2_flush_seq with SET_BITS=1, WAY_BITS=1, N_REQS=4: models the register
// block, request table and tag array, and compares walks against an expected line list.
module tb_l2_flush_seq;
  localparam int SB = 1, WB = 1, NR = 4;
  localparam int NS = 1 << SB, NW = 1 << WB, NL = NS * NW;
`ifdef L2_FLUSH_SKIP_CLEAN_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush_req, flush_busy, flush_done;
  logic [SB:0]   flush_set;
  logic [WB:0]   flush_way;
  logic [2:0]    reqs_cnt;
  logic          set_ongoing_flush, clr_ongoing_flush, incr_flush_set, clr_flush_set;
  logic          incr_flush_way, clr_flush_way, fill_reqs_flush;

  l2_flush_seq_if #(.SET_BITS(SB), .WAY_BITS(WB)) bus ();

  l2_flush_seq #(.SET_BITS(SB), .WAY_BITS(WB), .N_REQS(NR)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done), .flush_set(flush_set), .flush_way(flush_way),
    .reqs_cnt(reqs_cnt), .set_ongoing_flush(set_ongoing_flush),
    .clr_ongoing_flush(clr_ongoing_flush), .incr_flush_set(incr_flush_set),
    .clr_flush_set(clr_flush_set), .incr_flush_way(incr_flush_way),
    .clr_flush_way(clr_flush_way), .fill_reqs_flush(fill_reqs_flush), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0] vm;
    logic [NL-1:0] dm;
    int evp, lkp, rl, rt, n_ev_all, n_ev_dirty, gap;
  } vec_t;

  int tests = 0, fails = 0, cyc = 0;
  bit rst_drv, req_drv, noise, ev_pend;
  int cnt_set, cnt_way, slots, ovr, lk_stall, lk_pct, ev_pct, rsp_lat, ret_lat;
  int rsp_cd, rsp_idx, rsp_seen, fill_cnt, done_cnt, last_lk_cyc, done_cyc, pend_set, pend_way;
  logic [NL-1:0] vmask, dmask;
  int ret_q[$], lk_q[$], ev_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int outs();
    return int'({flush_busy, flush_done, set_ongoing_flush, clr_ongoing_flush,
                 incr_flush_set, clr_flush_set, incr_flush_way, clr_flush_way,
                 fill_reqs_flush, bus.lookup_valid, bus.evict_valid, bus.lookup_set,
                 bus.lookup_way, bus.evict_set, bus.evict_way});
  endfunction

  // One clock: drive inputs at negedge, sample what the DUT acts on at the next
  // posedge, then advance the environment models to their post-edge values.
  task automatic cycle();
    @(negedge clk);
    rst       = rst_drv;
    flush_set = (SB+1)'(cnt_set);
    flush_way = (WB+1)'(cnt_way);
    reqs_cnt  = 3'((ovr >= 0) ? ovr : slots);
    flush_req = req_drv | (noise && flush_busy && ($urandom_range(3) == 0));
    bus.lookup_ready     = (lk_stall > 0) ? 1'b0 : (int'($urandom_range(99)) < lk_pct);
    bus.evict_ready      = int'($urandom_range(99)) < ev_pct;
    bus.lookup_rsp_valid = 1'b0;
    bus.line_valid       = 1'($urandom_range(1));
    bus.line_dirty       = 1'($urandom_range(1));
    if (rsp_cd > 0) begin
      rsp_cd--;
      if (rsp_cd == 0) begin
        bus.lookup_rsp_valid = 1'b1;
        bus.line_valid       = vmask[rsp_idx];
        bus.line_dirty       = dmask[rsp_idx];
        rsp_cd               = -1;
        rsp_seen++;
      end
    end else if ($urandom_range(7) == 0) begin
      bus.lookup_rsp_valid = 1'b1;   // stray response, no lookup outstanding
    end
    #1;
    if (rst) begin
      ev_pend = 1'b0;
      rsp_cd  = -1;
    end else begin
      if (bus.lookup_valid) begin
        chk("lookup_set", int'(bus.lookup_set), cnt_set);
        chk("lookup_way", int'(bus.lookup_way), cnt_way);
      end
      if (bus.lookup_valid && bus.lookup_ready) begin
        chk("single_outstanding", rsp_cd, -1);
        rsp_idx = cnt_set * NW + cnt_way;
        rsp_cd  = rsp_lat;
        lk_q.push_back(rsp_idx);
        last_lk_cyc = cyc;
      end
      if (ev_pend) begin
        chk("evict_hold", int'(bus.evict_valid), 1);
        chk("evict_set_stable", int'(bus.evict_set), pend_set);
        chk("evict_way_stable", int'(bus.evict_way), pend_way);
      end
      if (bus.evict_valid) chk("evict_needs_slot", int'(reqs_cnt != 0), 1);
      if (bus.evict_valid || fill_reqs_flush)
        chk("fill_pulse", int'(fill_reqs_flush), int'(bus.evict_valid && bus.evict_ready));
      ev_pend  = bus.evict_valid && !bus.evict_ready;
      pend_set = int'(bus.evict_set);
      pend_way = int'(bus.evict_way);
      if (bus.evict_valid && bus.evict_ready) ev_q.push_back(pend_set * NW + pend_way);
      if (fill_reqs_flush) begin
        fill_cnt++;
        slots--;
        ret_q.push_back(cyc + ret_lat - 1);
      end
      if (flush_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_slots_full", int'(reqs_cnt), NR);
        chk("done_clr_ongoing", int'(clr_ongoing_flush), 1);
      end
      if (clr_flush_set) cnt_set = 0;
      else if (incr_flush_set) cnt_set++;
      if (clr_flush_way) cnt_way = 0;
      else if (incr_flush_way) cnt_way++;
    end
    while (ret_q.size() > 0 && ret_q[0] <= cyc) begin
      void'(ret_q.pop_front());
      slots++;
    end
    if (lk_stall > 0) lk_stall--;
    cyc++;
  endtask

  task automatic setup(input logic [NL-1:0] vm, input logic [NL-1:0] dm,
                       input int evp, input int lkp, input int rl, input int rt);
    vmask = vm; dmask = dm; ev_pct = evp; lk_pct = lkp; rsp_lat = rl; ret_lat = rt;
    lk_q.delete(); ev_q.delete();
    fill_cnt = 0; done_cnt = 0; done_cyc = -1; ev_pend = 1'b0;
  endtask

  task automatic start();
    req_drv = 1'b1;
    cycle();
    req_drv = 1'b0;
    cycle();
    chk("start_set_ongoing", int'(set_ongoing_flush), 1);
    chk("start_clr_counters", int'({clr_flush_set, clr_flush_way}), 3);
    chk("start_no_incr", int'({incr_flush_set, incr_flush_way, bus.lookup_valid}), 0);
    chk("start_busy", int'(flush_busy), 1);
  endtask

  // Runs the flush to completion and compares against the walk rules: every line
  // once in way-minor/set-major order, evictions for qualifying lines only.
  task automatic finish(input int gap);
    int n = 0;
    int exp_lk[$], exp_ev[$];
    while (done_cnt == 0 && n < 3000) begin
      cycle();
      n++;
    end
    chk("done_within_budget", done_cnt, 1);
    chk("busy_during_done", int'(flush_busy), 1);
    repeat (4) begin
      cycle();
      chk("busy_after_done", int'({flush_busy, flush_done}), 0);
    end
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        exp_lk.push_back(s * NW + w);
        if (vmask[s*NW+w] && (!SKIP || dmask[s*NW+w])) exp_ev.push_back(s * NW + w);
      end
    chk("lookup_count", lk_q.size(), exp_lk.size());
    for (int i = 0; i < lk_q.size() && i < exp_lk.size(); i++) chk("lookup_order", lk_q[i], exp_lk[i]);
    chk("evict_count", ev_q.size(), exp_ev.size());
    for (int i = 0; i < ev_q.size() && i < exp_ev.size(); i++) chk("evict_order", ev_q[i], exp_ev[i]);
    chk("fill_count", fill_cnt, exp_ev.size());
    chk("final_counters", cnt_set * NW + cnt_way, NL - 1);
    if (gap > 0) chk("done_latency", done_cyc - last_lk_cyc, gap);
  endtask

  initial begin
    int n, r0;
    vecs[0] = '{4'b0000, 4'b0000, 100, 100, 1, 3, 0, 0, 4};
    vecs[1] = '{4'b1111, 4'b0000, 100, 100, 1, 3, 4, 0, 0};
    vecs[2] = '{4'b1111, 4'b0100, 100, 100, 2, 3, 4, 1, 0};
    vecs[3] = '{4'b1010, 4'b1000,  60,  50, 2, 5, 2, 1, 0};
    vecs[4] = '{4'b0001, 4'b0001,  40,  70, 4, 2, 1, 1, 0};
    rst_drv = 1'b1; req_drv = 1'b0; noise = 1'b0;
    cnt_set = 1; cnt_way = 1; slots = NR; ovr = -1; lk_stall = 0; rsp_cd = -1; rsp_seen = 0;
    setup('0, '0, 100, 100, 1, 3);
    repeat (2) cycle();
    chk("reset_outputs", outs(), 0);
    rst_drv = 1'b0;
    cycle();
    chk("idle_outputs", outs(), 0);

    for (int i = 0; i < 5; i++) begin
      setup(vecs[i].vm, vecs[i].dm, vecs[i].evp, vecs[i].lkp, vecs[i].rl, vecs[i].rt);
      noise = (i == 2);
      start();
      finish(vecs[i].gap);
      chk("table_evicts", ev_q.size(), SKIP ? vecs[i].n_ev_dirty : vecs[i].n_ev_all);
      noise = 1'b0;
    end

    // No free slot while in EVICT: valid held low, then rises once a slot appears.
    setup('1, '1, 100, 100, 1, 20);
    ovr = 0;
    r0  = rsp_seen;
    start();
    n = 0;
    while (rsp_seen == r0 && n < 50) begin cycle(); n++; end
    chk("first_rsp_seen", rsp_seen - r0, 1);
    repeat (10) begin cycle(); chk("evict_blocked", int'(bus.evict_valid), 0); end
    ovr = 1; ev_pct = 0;
    repeat (3) begin
      cycle();
      chk("evict_on_one_slot", int'(bus.evict_valid), 1);
      chk("evict_payload", int'({bus.evict_set, bus.evict_way}), 0);
    end
    ovr = -1; ev_pct = 100;
    finish(0);

    // Lookup not accepted for 5 cycles, 3-cycle read latency.
    setup(4'b0110, 4'b0110, 100, 100, 3, 2);
    start();
    lk_stall = 5;
    repeat (5) begin
      cycle();
      chk("lookup_held", int'(bus.lookup_valid), 1);
      chk("lookup_addr_held", int'({bus.lookup_set, bus.lookup_way}), 0);
      chk("no_strobe_in_lookup", int'({incr_flush_set, clr_flush_set, incr_flush_way, clr_flush_way}), 0);
    end
    finish(0);

    // Reset while stalled in EVICT at (1,1), then a fresh flush right after reset.
    setup(4'b1000, 4'b1000, 0, 100, 1, 3);
    start();
    n = 0;
    while (!bus.evict_valid && n < 100) begin cycle(); n++; end
    chk("reached_evict", int'(bus.evict_valid), 1);
    rst_drv = 1'b1;
    cycle();
    cycle();
    chk("reset_mid_flush", outs(), 0);
    rst_drv = 1'b0;
    cycle();
    chk("after_reset_idle", outs(), 0);
    setup(4'b1000, 4'b1000, 100, 100, 1, 3);
    start();
    finish(0);

    for (int t = 0; t < 10; t++) begin
      setup(NL'($urandom), NL'($urandom), int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
            int'($urandom_range(4, 1)), int'($urandom_range(6, 1)));
      noise = 1'b1;
      start();
      finish(0);
      noise = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
